// File: rtl/note_detect.sv
// note_detect: picks the loudest FFT bin in each frame, applies a loudness threshold,
// and publishes the note only after STABLE_FRAMES matching frames in a row.
module note_detect #(
   parameter int         FRAME_SAMPLES = 16384,
   parameter logic [9:0] THRESH        = 10'd64,
   parameter int         STABLE_FRAMES = 3
) (
   input  logic        clock_27mhz,
   input  logic        reset,
   input  logic        ready,
   input  logic [11:0] haddr,
   input  logic [9:0]  hdata,
   input  logic        hwe,
   output logic [11:0] note_bin,
   output logic [9:0]  note_mag,
   output logic        note_valid,
   output logic        note_strobe
);
   localparam int FW = FRAME_SAMPLES > 1 ? $clog2(FRAME_SAMPLES) : 1;
   typedef enum logic [1:0] {ACC, EVAL, COMMIT} state_t;
   state_t      state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [9:0]  max_mag_q, max_mag_d, peak_q, peak_d, note_mag_q, note_mag_d, acc_mag;
   logic [11:0] max_bin_q, max_bin_d, prev_bin_q, prev_bin_d, note_bin_q, note_bin_d, cand_bin;
   logic        prev_valid_q, prev_valid_d, note_valid_q, note_valid_d;
   logic        note_strobe_q, note_strobe_d, cand_valid, frame_end;
   logic [3:0]  run_q, run_d;
   always_comb begin
      frame_end = ready && fcnt_q == FW'(FRAME_SAMPLES - 1);
      fcnt_d = ready ? (frame_end ? '0 : fcnt_q + 1'b1) : fcnt_q;
      state_d = state_q == ACC ? (frame_end ? EVAL : ACC) : (state_q == EVAL ? COMMIT : ACC);
      // The accumulator is cleared in EVAL, so a write landing there seeds the next frame
      acc_mag = state_q == EVAL ? '0 : max_mag_q;
      max_mag_d = acc_mag;
      max_bin_d = state_q == EVAL ? '0 : max_bin_q;
      if (hwe && hdata > acc_mag) begin
         max_mag_d = hdata;
         max_bin_d = haddr;
      end
      cand_valid = max_mag_q >= THRESH;
      cand_bin = cand_valid ? max_bin_q : '0;
      run_d = run_q;
      prev_bin_d = prev_bin_q;
      prev_valid_d = prev_valid_q;
      peak_d = peak_q;
      if (state_q == EVAL) begin
         run_d = (cand_bin == prev_bin_q && cand_valid == prev_valid_q) ?
                 (run_q == 4'd15 ? run_q : run_q + 1'b1) : 4'd1;
         prev_bin_d = cand_bin;
         prev_valid_d = cand_valid;
         peak_d = max_mag_q;
      end
      note_bin_d = note_bin_q;
      note_mag_d = note_mag_q;
      note_valid_d = note_valid_q;
      note_strobe_d = 1'b0;
      if (state_q == COMMIT && run_q >= 4'(STABLE_FRAMES) &&
          (prev_bin_q != note_bin_q || prev_valid_q != note_valid_q)) begin
         note_bin_d = prev_bin_q;
         note_mag_d = peak_q;
         note_valid_d = prev_valid_q;
         note_strobe_d = 1'b1;
      end
   end
   always_ff @(posedge clock_27mhz) begin
      if (reset) begin
         state_q <= ACC;
         fcnt_q <= '0;
         max_mag_q <= '0;
         max_bin_q <= '0;
         peak_q <= '0;
         prev_bin_q <= '0;
         prev_valid_q <= 1'b0;
         run_q <= '0;
         note_bin_q <= '0;
         note_mag_q <= '0;
         note_valid_q <= 1'b0;
         note_strobe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q <= fcnt_d;
         max_mag_q <= max_mag_d;
         max_bin_q <= max_bin_d;
         peak_q <= peak_d;
         prev_bin_q <= prev_bin_d;
         prev_valid_q <= prev_valid_d;
         run_q <= run_d;
         note_bin_q <= note_bin_d;
         note_mag_q <= note_mag_d;
         note_valid_q <= note_valid_d;
         note_strobe_q <= note_strobe_d;
      end
   end
   assign note_bin = note_bin_q;
   assign note_mag = note_mag_q;
   assign note_valid = note_valid_q;
   assign note_strobe = note_strobe_q;
endmodule

// File: tb/tb_note_detect.sv
// tb_note_detect: table-driven frame vectors for note_detect with FRAME_SAMPLES=8.
module tb_note_detect;
   logic clk = 1'b0;
   logic reset = 1'b1, ready = 1'b0, hwe = 1'b0;
   logic [11:0] haddr = '0;
   logic [9:0] hdata = '0;
   logic [11:0] note_bin;
   logic [9:0] note_mag;
   logic note_valid, note_strobe;
   int checks = 0, fails = 0;

   note_detect #(.FRAME_SAMPLES(8), .THRESH(10'd64), .STABLE_FRAMES(3)) dut (
      .clock_27mhz(clk), .reset(reset), .ready(ready), .haddr(haddr), .hdata(hdata),
      .hwe(hwe), .note_bin(note_bin), .note_mag(note_mag), .note_valid(note_valid),
      .note_strobe(note_strobe));

   always #5 clk = ~clk;

   // One frame = 8 ready cycles (writes at cycles k0..k2), then 4 idle cycles.
   // Idle 0 is EVAL (optional write ew), idle 1 is COMMIT, idle 2 shows the strobe.
   typedef struct {
      logic [11:0] b0, b1, b2;
      logic [9:0]  m0, m1, m2;
      int          k0, k1, k2, nw, rs;
      bit          ew;
      logic [11:0] eb;
      logic [9:0]  em;
      bit          es;
      logic [11:0] xb;
      logic [9:0]  xm;
      bit          xv;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic [11:0] b0, input logic [9:0] m0,
                               input logic [11:0] b1, input logic [9:0] m1,
                               input logic [11:0] b2, input logic [9:0] m2, input int nw,
                               input bit es, input logic [11:0] xb, input logic [9:0] xm,
                               input bit xv);
      vec_t v;
      v.b0 = b0; v.m0 = m0; v.b1 = b1; v.m1 = m1; v.b2 = b2; v.m2 = m2; v.nw = nw;
      v.k0 = 2; v.k1 = 3; v.k2 = 4; v.rs = -1; v.ew = 0; v.eb = '0; v.em = '0;
      v.es = es; v.xb = xb; v.xm = xm; v.xv = xv;
      return v;
   endfunction

   task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s vec%0d: got %0h want %0h", nm, idx, got, want);
      end
   endtask

   task automatic run_vec(input vec_t v, output logic [4:0] sp);
      sp = '0;
      for (int k = 0; k < 8; k++) begin
         ready = 1'b1; hwe = 1'b0; haddr = '0; hdata = '0;
         if (v.nw > 0 && v.k0 == k) begin hwe = 1'b1; haddr = v.b0; hdata = v.m0; end
         if (v.nw > 1 && v.k1 == k) begin hwe = 1'b1; haddr = v.b1; hdata = v.m1; end
         if (v.nw > 2 && v.k2 == k) begin hwe = 1'b1; haddr = v.b2; hdata = v.m2; end
         @(negedge clk);
         if (note_strobe) sp[4] = 1'b1;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
         ready = 1'b0;
         hwe = i == 0 && v.ew;
         haddr = v.eb;
         hdata = v.em;
         reset = i == v.rs;
         @(negedge clk);
         sp[i] = note_strobe;
         @(posedge clk); #1;
      end
      reset = 1'b0; hwe = 1'b0;
   endtask

   initial begin
      vec_t v;
      logic [4:0] sp;
      logic [11:0] A = 12'h100, B = 12'h200, C = 12'h077;
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0));
      for (int f = 0; f < 3; f++)
         tbl.push_back(mk(12'h02A, 100, 12'h11B, 300, 12'h0D4, 299, 3, f == 2,
                          f == 2 ? 12'h11B : 12'h000, f == 2 ? 10'd300 : 10'd0, f == 2));
      tbl.push_back(mk(12'h02A, 100, 12'h11B, 300, 12'h0D4, 299, 3, 0, 12'h11B, 300, 1));
      for (int f = 0; f < 3; f++)
         tbl.push_back(mk(12'h02C, 200, 12'h012, 200, 0, 0, 2, f == 2,
                          f == 2 ? 12'h02C : 12'h11B, f == 2 ? 10'd200 : 10'd300, 1));
      for (int f = 0; f < 3; f++)
         tbl.push_back(mk(12'h050, 63, 12'h060, 10, 0, 0, 2, f == 2,
                          f == 2 ? 12'h000 : 12'h02C, f == 2 ? 10'd63 : 10'd200, f != 2));
      for (int f = 0; f < 3; f++)
         tbl.push_back(mk(12'h033, 64, 0, 0, 0, 0, 1, f == 2,
                          f == 2 ? 12'h033 : 12'h000, f == 2 ? 10'd64 : 10'd63, f == 2));
      for (int f = 0; f < 6; f++)
         tbl.push_back(mk(f == 2 ? B : A, f == 2 ? 10'd400 : 10'd500, 0, 0, 0, 0, 1, f == 5,
                          f == 5 ? A : 12'h033, f == 5 ? 10'd500 : 10'd64, 1));
      for (int f = 0; f < 3; f++) begin
         v = mk(12'h010, 300, 12'h016, 500, 0, 0, 2, f == 2,
                f == 2 ? 12'h016 : A, f == 2 ? 10'd500 : 10'd500, 1);
         v.k1 = 7;
         tbl.push_back(v);
      end
      for (int f = 0; f < 4; f++) begin
         v = mk(12'h020, 300, 0, 0, 0, 0, 1, f == 3, f == 3 ? 12'h042 : 12'h016,
                f == 3 ? 10'd400 : 10'd500, 1);
         v.ew = f < 3; v.eb = 12'h042; v.em = 400;
         tbl.push_back(v);
      end
      for (int f = 0; f < 3; f++) begin
         v = mk(C, 250, 0, 0, 0, 0, 1, 0, f == 2 ? 12'h000 : 12'h042,
                f == 2 ? 10'd0 : 10'd400, f != 2);
         if (f == 2) v.rs = 1;
         tbl.push_back(v);
      end
      for (int f = 0; f < 3; f++)
         tbl.push_back(mk(C, 250, 0, 0, 0, 0, 1, f == 2, f == 2 ? C : 12'h000,
                          f == 2 ? 10'd250 : 10'd0, f == 2));

      for (int c = 0; c < 2; c++) begin
         reset = 1'b1;
         ready = 1'($urandom_range(0, 1));
         hwe = 1'($urandom_range(0, 1));
         haddr = 12'($urandom);
         hdata = 10'($urandom);
         @(negedge clk);
         if (c == 1) begin
            check("reset_bin", -1, 32'(note_bin), 0);
            check("reset_mag", -1, 32'(note_mag), 0);
            check("reset_valid", -1, 32'(note_valid), 0);
            check("reset_strobe", -1, 32'(note_strobe), 0);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0; ready = 1'b0; hwe = 1'b0;

      foreach (tbl[i]) begin
         run_vec(tbl[i], sp);
         check("strobe", i, 32'(sp), tbl[i].es ? 32'b00100 : 32'b0);
         check("bin", i, 32'(note_bin), 32'(tbl[i].xb));
         check("mag", i, 32'(note_mag), 32'(tbl[i].xm));
         check("valid", i, 32'(note_valid), 32'(tbl[i].xv));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/note_detect.md
# note_detect

Per-frame spectral peak picker and debouncer. It sits directly downstream of the FFT magnitude stage and consumes its (`haddr`, `hdata`, `hwe`) bin-magnitude writes. Over each FFT frame it finds the loudest monitored bin, gates it against a loudness threshold, and requires the same result for several consecutive frames. Only then does it publish a stable note bin to the game logic.

## Interface
Parameters:
- `FRAME_SAMPLES`, default 16384: `ready` strobes per FFT frame (the FFT transform length).
- `THRESH`, default 10'd64: minimum peak magnitude counted as a played note.
- `STABLE_FRAMES`, default 3: consecutive identical frame results (1..15) required before the output changes.

Ports:
- `clock_27mhz`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high; clock clock_27mhz.
- `ready`, in, 1: one-cycle AC97 sample strobe; the same signal that enables the FFT.
- `haddr`, in, 12: FFT bin index of the current magnitude write.
- `hdata`, in, 10: unsigned bin magnitude.
- `hwe`, in, 1: one-cycle magnitude write strobe.
- `note_bin`, out, 12: committed peak bin; 0 when `note_valid`=0.
- `note_mag`, out, 10: peak magnitude of the frame that caused the last commit.
- `note_valid`, out, 1: 1 = a note is held; 0 = silence.
- `note_strobe`, out, 1: one-cycle pulse whenever `note_bin` or `note_valid` changes.

## Operation
- Frame counter `fcnt`, width clog2(`FRAME_SAMPLES`):
  - Increments on each `ready`.
  - On the `ready` where `fcnt`=`FRAME_SAMPLES`-1 it wraps to 0 and the FSM leaves ACC.
- FSM states: ACC, EVAL, COMMIT. Reset state is ACC.
- ACC, on each `hwe`:
  - If `hdata` > `max_mag` (strictly greater), then `max_mag`<=`hdata` and `max_bin`<=`haddr`.
  - On a tie the earlier bin is kept.
  - If `ready` ends the frame in the same cycle as `hwe`, that write is still included.
- EVAL, one cycle:
  - Candidate = (`max_bin`, valid=1) if `max_mag` >= `THRESH`; otherwise (0, valid=0).
  - If candidate equals the previous frame's candidate (bin and valid), `run` increments, saturating at 15. Otherwise `run`<=1.
  - The candidate is stored as the previous candidate.
  - The accumulator clears: `max_mag`<=0, `max_bin`<=0.
  - If `hwe` arrives in this cycle, it seeds the cleared accumulator (`max_mag`<=`hdata`, `max_bin`<=`haddr`).
- COMMIT, one cycle:
  - If `run` >= `STABLE_FRAMES` and the candidate differs from the current (`note_bin`, `note_valid`), load the candidate and `note_mag`<=frame peak, and assert `note_strobe` next cycle.
  - Otherwise outputs hold.
  - Then return to ACC.
  - An `hwe` in COMMIT is accumulated normally into the new frame.
- `ready` in EVAL or COMMIT is still counted by `fcnt`. With FRAME_SAMPLES >= 3, a frame cannot end during EVAL or COMMIT.
- Silence also requires `STABLE_FRAMES` consecutive sub-threshold frames before `note_valid` falls.
- Before the first frame end, `prev` candidate is (0, invalid) and `run`=0.

## Timing
- Reset values: `note_bin`=0, `note_mag`=0, `note_valid`=0, `note_strobe`=0, `fcnt`=0, `run`=0, `max_mag`=0, `max_bin`=0, state ACC.
- Reset takes priority over everything. A reset asserted in EVAL or COMMIT discards the frame without a strobe.
- Latency from the frame-ending `ready` edge:
  - cycle +1: EVAL.
  - cycle +2: COMMIT.
  - cycle +3: new `note_*` visible, `note_strobe` high for exactly that cycle.
- All outputs are registered; there are no combinational input-to-output paths.
- Magnitude compare is unsigned 10-bit. `hdata`=0 never replaces the initial `max_mag`=0, so an all-zero frame gives `max_bin`=0.

## Test plan
(Benches use FRAME_SAMPLES=8, THRESH=64, STABLE_FRAMES=3.)
- Reset: hold `reset` 2 cycles with random `ready`/`hwe` -> all outputs 0, no strobe; after release, 8 `ready` pulses with no `hwe` -> no strobe, `note_valid`=0.
- Stable note: three frames, each with writes (0x02A,100), (0x11B,300), (0x0D4,299) -> no strobe after frames 1–2. Frame 3 end +3 cycles gives `note_bin`=0x11B, `note_mag`=300, `note_valid`=1, and a one-cycle strobe. A fourth identical frame -> no strobe.
- Tie and threshold: writes (0x02C,200) then (0x012,200) for 3 frames -> `note_bin`=0x02C. Then 3 frames with peak 63 -> `note_valid`=0, `note_bin`=0, strobe once. A frame with peak exactly 64 counts as valid.
- Debounce break: frames peaking at bins A, A, B, A, A, A -> single strobe to A after frame 6 only.
- Boundary writes: `hwe` (0x016,500) coincident with the frame-ending `ready` counts in the old frame. `hwe` (0x042,400) in the EVAL cycle counts in the new frame. Check both via committed `note_bin` after 3 repetitions.
- Mid-operation reset: assert `reset` in the COMMIT cycle of a frame that would commit -> no strobe, outputs 0, and the next commit needs 3 fresh stable frames.
